dma_cmd_seq: RTL and testbench

Command-side initiator for the tiny DMA core; it is the block that drives the core's 8-bit config bus and consumes its done pulse.
- Buffers up to DEPTH transfer descriptors from a host valid/ready port.
- Issues each descriptor as a single-cycle start command on cfg_out, then waits for dma_done with a timeout.
- Captures the last transferred word and counts completed commands.
- Sits between the host/test controller and the DMA core's cfg_in/data_out/dma_done pins.

---
 rtl/dma_cmd_seq.sv | 203 ++++++++++++++++++++
 tb/tb_dma_cmd_seq.sv | 323 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/dma_cmd_seq.sv
// -----------------------------------------------------------------------------
// dma_cmd_seq
//
// Command-side initiator for the tiny DMA core. Descriptors from the host
// are buffered in a small FIFO. Each one is issued to the core as a single
// cycle start command on cfg_out. The sequencer then waits for dma_done,
// with a timeout. On completion it captures the last transferred word and
// counts the command.
//
// Parameters
//   DEPTH    descriptor FIFO depth (power of 2, 2..8)
//   TIMEOUT  cycles allowed in WAIT before a timeout is declared (8..15)
//
// Ports
//   clk         clock
//   rst         asynchronous reset, active-low
//   desc_in     descriptor {src[2:0], dst[2:0], burst}
//   desc_valid  host presents a descriptor
//   desc_ready  a push is accepted this cycle (desc_valid & desc_ready)
//   cfg_out     to DMA cfg_in: {start, desc}, start high for one cycle only
//   dma_data    from DMA data_out
//   dma_done    from DMA done pulse
//   busy        FIFO non-empty or sequencer not idle
//   last_data   dma_data captured on the accepted dma_done
//   cmd_count   completed commands, wraps 15 -> 0
//   err         sticky timeout flag
//   err_clr     synchronous clear of err (a coincident timeout wins)
//   chksum      XOR of retired last_data values
//
// Optional feature
//   DMA_SEQ_CHKSUM_EN  when defined, chksum accumulates last_data on every
//                      retire. When undefined, chksum is tied to zero and
//                      no accumulator exists.
// -----------------------------------------------------------------------------
module dma_cmd_seq #(
  parameter int DEPTH   = 4,
  parameter int TIMEOUT = 15
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [6:0] desc_in,
  input  logic       desc_valid,
  output logic       desc_ready,
  output logic [7:0] cfg_out,
  input  logic [6:0] dma_data,
  input  logic       dma_done,
  output logic       busy,
  output logic [6:0] last_data,
  output logic [3:0] cmd_count,
  output logic       err,
  input  logic       err_clr,
  output logic [6:0] chksum
);

  localparam int             AW       = $clog2(DEPTH);
  localparam logic [AW:0]    PTR_ONE  = (AW+1)'(1);
  localparam logic [3:0]     TMO_LAST = 4'(TIMEOUT - 1);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ISSUE  = 2'd1,
    WAIT   = 2'd2,
    RETIRE = 2'd3
  } state_t;

  state_t      state_reg;
  logic [7:0]  cfg_reg;
  logic [3:0]  timer_reg;
  logic [6:0]  last_data_reg;
  logic [3:0]  cmd_count_reg;
  logic        err_reg;

  // ---------------------------------------------------------------------------
  // Descriptor FIFO. The pointers carry one extra wrap bit, so that full and
  // empty can be told apart.
  // ---------------------------------------------------------------------------
  logic [6:0]  fifo_mem [DEPTH];
  logic [AW:0] wr_ptr_reg;
  logic [AW:0] rd_ptr_reg;
  logic        fifo_empty;
  logic        fifo_full;
  logic        push;
  logic        pop;
  logic        timeout_hit;

  assign fifo_empty = (wr_ptr_reg == rd_ptr_reg);
  assign fifo_full  = (wr_ptr_reg[AW] != rd_ptr_reg[AW]) &&
                      (wr_ptr_reg[AW-1:0] == rd_ptr_reg[AW-1:0]);

  // The head is released in RETIRE. A full FIFO can therefore take a new
  // entry in that same cycle, and occupancy stays at DEPTH. RETIRE is a
  // registered state, so desc_ready has no path from dma_done.
  assign desc_ready = !fifo_full || (state_reg == RETIRE);
  assign push       = desc_valid && desc_ready;

  // Timeout fires only when done is absent, because done has priority.
  assign timeout_hit = (state_reg == WAIT) && !dma_done && (timer_reg == TMO_LAST);
  assign pop         = (state_reg == RETIRE) || timeout_hit;

  always_ff @(posedge clk) begin
    if (push) begin
      fifo_mem[wr_ptr_reg[AW-1:0]] <= desc_in;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
    end else begin
      if (push) begin
        wr_ptr_reg <= wr_ptr_reg + PTR_ONE;
      end
      if (pop) begin
        rd_ptr_reg <= rd_ptr_reg + PTR_ONE;
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Command FSM. cfg_out is loaded on the IDLE->ISSUE transition, so start is
  // visible for exactly the ISSUE cycle. Every other state drives 0x00.
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_reg     <= IDLE;
      cfg_reg       <= 8'h00;
      timer_reg     <= 4'd0;
      last_data_reg <= 7'd0;
      cmd_count_reg <= 4'd0;
      err_reg       <= 1'b0;
    end else begin
      cfg_reg <= 8'h00;

      // Clear first, so that a timeout set later in this block wins.
      if (err_clr) begin
        err_reg <= 1'b0;
      end

      case (state_reg)
        IDLE: begin
          if (!fifo_empty) begin
            cfg_reg   <= {1'b1, fifo_mem[rd_ptr_reg[AW-1:0]]};
            state_reg <= ISSUE;
          end
        end

        ISSUE: begin
          timer_reg <= 4'd0;
          state_reg <= WAIT;
        end

        WAIT: begin
          timer_reg <= timer_reg + 4'd1;
          if (dma_done) begin
            last_data_reg <= dma_data;
            state_reg     <= RETIRE;
          end else if (timer_reg == TMO_LAST) begin
            // The head is dropped by the FIFO pop. Count and data are kept.
            err_reg   <= 1'b1;
            state_reg <= IDLE;
          end
        end

        RETIRE: begin
          cmd_count_reg <= cmd_count_reg + 4'd1;
          state_reg     <= IDLE;
        end

        default: begin
          state_reg <= IDLE;
        end
      endcase
    end
  end

  assign cfg_out   = cfg_reg;
  assign last_data = last_data_reg;
  assign cmd_count = cmd_count_reg;
  assign err       = err_reg;
  assign busy      = (state_reg != IDLE) || !fifo_empty;

  // ---------------------------------------------------------------------------
  // Optional checksum of retired words. In RETIRE, last_data_reg already holds
  // the word captured on dma_done, so that word is the one folded in.
  // ---------------------------------------------------------------------------
`ifdef DMA_SEQ_CHKSUM_EN
  logic [6:0] chksum_reg;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      chksum_reg <= 7'd0;
    end else if (state_reg == RETIRE) begin
      chksum_reg <= chksum_reg ^ last_data_reg;
    end
  end

  assign chksum = chksum_reg;
`else
  assign chksum = 7'd0;
`endif

endmodule

// File: tb/tb_dma_cmd_seq.sv
// -----------------------------------------------------------------------------
// tb_dma_cmd_seq
//
// Directed bench for dma_cmd_seq. A small behavioural stand-in for the DMA
// core answers each start command. Its memory holds 61,62,63,64,0,0,0,0.
// It raises dma_done 3 cycles (single) or 5 cycles (burst) after start, and
// returns the last source word.
// The core can be stalled, or given an override latency.
// -----------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_dma_cmd_seq;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic [6:0] desc_in = 7'd0;
  logic       desc_valid = 1'b0;
  logic       desc_ready;
  logic [7:0] cfg_out;
  logic [6:0] dma_data = 7'd0;
  logic       dma_done = 1'b0;
  logic       busy;
  logic [6:0] last_data;
  logic [3:0] cmd_count;
  logic       err;
  logic       err_clr = 1'b0;
  logic [6:0] chksum;

  always #5 clk = ~clk;

  dma_cmd_seq #(.DEPTH(4), .TIMEOUT(15)) dut (
    .clk        (clk),
    .rst        (rst),
    .desc_in    (desc_in),
    .desc_valid (desc_valid),
    .desc_ready (desc_ready),
    .cfg_out    (cfg_out),
    .dma_data   (dma_data),
    .dma_done   (dma_done),
    .busy       (busy),
    .last_data  (last_data),
    .cmd_count  (cmd_count),
    .err        (err),
    .err_clr    (err_clr),
    .chksum     (chksum)
  );

`ifdef DMA_SEQ_CHKSUM_EN
  localparam logic [6:0] CHK_MASK = 7'h7F;
`else
  localparam logic [6:0] CHK_MASK = 7'h00;
`endif

  int tests_run    = 0;
  int tests_failed = 0;

  // ---------------------------------------------------------------------------
  // DMA core stand-in. It acts 1ns after each rising edge. The bench's own
  // drives and samples happen 2ns after the edge.
  // ---------------------------------------------------------------------------
  logic [6:0] core_mem [0:7] = '{7'h61, 7'h62, 7'h63, 7'h64, 7'h00, 7'h00, 7'h00, 7'h00};
  bit         core_stall = 1'b0;
  int         ovr_delay  = 0;
  int         core_cnt   = 0;
  bit         prev_start = 1'b0;
  int         b2b_cnt    = 0;
  logic [6:0] last_word  = 7'd0;
  logic [6:0] issued [0:63];
  int         issued_n   = 0;

  always @(posedge clk) begin
    logic [2:0] src;
    #1;
    if (!rst) begin
      core_cnt   = 0;
      dma_done   = 1'b0;
      prev_start = 1'b0;
    end else begin
      dma_done = 1'b0;
      if (core_cnt != 0 && !(core_stall && core_cnt == 1)) begin
        core_cnt = core_cnt - 1;
        if (core_cnt == 0) begin
          dma_done = 1'b1;
          dma_data = last_word;
        end
      end
      if (cfg_out[7]) begin
        if (prev_start) b2b_cnt++;
        issued[issued_n[5:0]] = cfg_out[6:0];
        issued_n++;
        src       = cfg_out[6:4];
        last_word = cfg_out[0] ? core_mem[src + 3'd2] : core_mem[src];
        core_cnt  = (ovr_delay != 0) ? ovr_delay : (cfg_out[0] ? 5 : 3);
      end
      prev_start = cfg_out[7];
    end
  end

  // ---------------------------------------------------------------------------
  // Helpers
  // ---------------------------------------------------------------------------
  task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    tests_run++;
    assert (obs === exp) else begin
      tests_failed++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic push(input logic [6:0] d, output logic acc);
    desc_in    = d;
    desc_valid = 1'b1;
    acc        = desc_ready;
    tick();
    desc_valid = 1'b0;
  endtask

  task automatic wait_start(input string tag);
    int n = 0;
    while (cfg_out[7] !== 1'b1 && n < 40) begin
      tick();
      n++;
    end
    check(tag, 8'(cfg_out[7]), 8'h01);
  endtask

  task automatic wait_idle(input string tag, input int budget);
    int n = 0;
    while (busy !== 1'b0 && n < budget) begin
      tick();
      n++;
    end
    check(tag, 8'(busy), 8'h00);
  endtask

  // ---------------------------------------------------------------------------
  // Directed sequence
  // ---------------------------------------------------------------------------
  initial begin
    logic       acc;
    logic [6:0] exp_chk;
    logic [6:0] t4_desc [0:3];
    logic [6:0] t6_desc [0:4];
    int         base;
    int         n;

    t4_desc = '{7'h10, 7'h01, 7'h30, 7'h20};
    t6_desc = '{7'h30, 7'h10, 7'h20, 7'h01, 7'h3E};
    exp_chk = 7'h00;

    repeat (3) @(posedge clk);
    #2 rst = 1'b1;

    // Reset state
    check("rst_cfg_out",   cfg_out, 8'h00);
    check("rst_last_data", 8'(last_data), 8'h00);
    check("rst_cmd_count", 8'(cmd_count), 8'h00);
    check("rst_err",       8'(err), 8'h00);
    check("rst_chksum",    8'(chksum), 8'h00);
    check("rst_ready",     8'(desc_ready), 8'h01);
    check("rst_busy",      8'(busy), 8'h00);

    // 1: burst src0 -> dst4; last word 0x63
    push(7'h09, acc);
    check("t1_accept", 8'(acc), 8'h01);
    wait_start("t1_start_seen");
    check("t1_cfg_out", cfg_out, 8'h89);
    tick();
    check("t1_start_1cyc", cfg_out, 8'h00);
    n = 0;
    while (dma_done !== 1'b1 && n < 20) begin
      tick();
      n++;
    end
    check("t1_done_seen", 8'(dma_done), 8'h01);
    tick();
    check("t1_last_data", 8'(last_data), 8'h63);
    check("t1_busy_retire", 8'(busy), 8'h01);
    tick();
    check("t1_cmd_count", 8'(cmd_count), 8'h01);
    check("t1_busy_low", 8'(busy), 8'h00);
    exp_chk = exp_chk ^ 7'h63;

    // 2: single src3 -> dst7; last word 0x64
    push(7'h3E, acc);
    wait_start("t2_start_seen");
    check("t2_cfg_out", cfg_out, 8'hBE);
    tick();
    check("t2_start_1cyc", cfg_out, 8'h00);
    wait_idle("t2_idle", 40);
    exp_chk = exp_chk ^ 7'h64;
    check("t2_last_data", 8'(last_data), 8'h64);
    check("t2_cmd_count", 8'(cmd_count), 8'h02);
    check("t2_chksum", 8'(chksum), 8'(exp_chk & CHK_MASK));

    // 3: no done -> timeout. The ISSUE cycle plus 15 WAIT cycles means err is
    // seen 16 edges after start. err_clr is raised on the timeout edge and
    // must lose.
    core_stall = 1'b1;
    push(7'h00, acc);
    wait_start("t3_start_seen");
    for (int k = 1; k <= 16; k++) begin
      tick();
      if (k == 8)  check("t3_cfg_idle_in_wait", cfg_out, 8'h00);
      if (k == 15) begin
        check("t3_err_before", 8'(err), 8'h00);
        err_clr = 1'b1;
      end
      if (k == 16) check("t3_err_set_wins", 8'(err), 8'h01);
    end
    check("t3_fifo_empty_busy", 8'(busy), 8'h00);
    check("t3_ready", 8'(desc_ready), 8'h01);
    check("t3_cmd_count", 8'(cmd_count), 8'h02);
    check("t3_last_data", 8'(last_data), 8'h64);
    tick();
    err_clr = 1'b0;
    check("t3_err_cleared", 8'(err), 8'h00);
    // The stalled done now arrives while idle and must be ignored.
    core_stall = 1'b0;
    repeat (3) tick();
    check("t3_late_done_count", 8'(cmd_count), 8'h02);
    check("t3_late_done_data", 8'(last_data), 8'h64);
    check("t3_late_done_busy", 8'(busy), 8'h00);

    // Done in the last WAIT cycle beats the timeout
    ovr_delay = 15;
    push(7'h00, acc);
    wait_idle("tp_idle", 60);
    ovr_delay = 0;
    exp_chk = exp_chk ^ 7'h61;
    check("tp_err", 8'(err), 8'h00);
    check("tp_cmd_count", 8'(cmd_count), 8'h03);
    check("tp_last_data", 8'(last_data), 8'h61);
    check("tp_chksum", 8'(chksum), 8'(exp_chk & CHK_MASK));

    // 4: stalled core, five back-to-back pushes -> four accepted
    core_stall = 1'b1;
    base = issued_n;
    for (int i = 0; i < 4; i++) begin
      push(t4_desc[i], acc);
      check($sformatf("t4_accept%0d", i), 8'(acc), 8'h01);
    end
    push(7'h7F, acc);
    check("t4_reject5", 8'(acc), 8'h00);
    check("t4_busy", 8'(busy), 8'h01);
    core_stall = 1'b0;
    wait_idle("t4_idle", 200);
    check("t4_cmd_count", 8'(cmd_count), 8'h07);
    check("t4_last_data", 8'(last_data), 8'h63);
    check("t4_issued_n", 8'(issued_n - base), 8'h04);
    for (int i = 0; i < 4; i++)
      check($sformatf("t4_order%0d", i), 8'(issued[(base + i) % 64]), 8'(t4_desc[i]));
    exp_chk = exp_chk ^ 7'h62 ^ 7'h63 ^ 7'h64 ^ 7'h63;
    check("t4_chksum", 8'(chksum), 8'(exp_chk & CHK_MASK));
    check("t4_no_b2b", 8'(b2b_cnt), 8'h00);

    // 6: push coincident with the RETIRE pop while full
    core_stall = 1'b1;
    base = issued_n;
    for (int i = 0; i < 4; i++) begin
      push(t6_desc[i], acc);
      check($sformatf("t6_accept%0d", i), 8'(acc), 8'h01);
    end
    check("t6_full", 8'(desc_ready), 8'h00);
    core_stall = 1'b0;
    n = 0;
    while (desc_ready !== 1'b1 && n < 20) begin
      tick();
      n++;
    end
    check("t6_ready_in_retire", 8'(desc_ready), 8'h01);
    check("t6_count_in_retire", 8'(cmd_count), 8'h07);
    push(t6_desc[4], acc);
    check("t6_still_full", 8'(desc_ready), 8'h00);
    wait_idle("t6_idle", 200);
    check("t6_cmd_count", 8'(cmd_count), 8'h0C);
    check("t6_last_data", 8'(last_data), 8'h64);
    check("t6_issued_n", 8'(issued_n - base), 8'h05);
    for (int i = 0; i < 5; i++)
      check($sformatf("t6_order%0d", i), 8'(issued[(base + i) % 64]), 8'(t6_desc[i]));
    exp_chk = exp_chk ^ 7'h64 ^ 7'h62 ^ 7'h63 ^ 7'h63 ^ 7'h64;
    check("t6_chksum", 8'(chksum), 8'(exp_chk & CHK_MASK));
    check("t6_no_b2b", 8'(b2b_cnt), 8'h00);

    // cmd_count wraps 15 -> 0 after four more singles
    for (int i = 0; i < 4; i++) push(7'h00, acc);
    wait_idle("wrap_idle", 200);
    check("wrap_cmd_count", 8'(cmd_count), 8'h00);
    check("wrap_last_data", 8'(last_data), 8'h61);

    // 5: reset during WAIT of a burst, with a second descriptor queued
    push(7'h3E, acc);
    wait_idle("t5_pre_idle", 40);
    check("t5_pre_count", 8'(cmd_count), 8'h01);
    push(7'h01, acc);
    wait_start("t5_start_seen");
    push(7'h30, acc);
    tick();
    check("t5_busy_before", 8'(busy), 8'h01);
    base = issued_n;
    rst = 1'b0;
    #1;
    check("t5_cfg_out", cfg_out, 8'h00);
    check("t5_cmd_count", 8'(cmd_count), 8'h00);
    check("t5_busy", 8'(busy), 8'h00);
    check("t5_ready", 8'(desc_ready), 8'h01);
    check("t5_last_data", 8'(last_data), 8'h00);
    check("t5_chksum", 8'(chksum), 8'h00);
    tick();
    rst = 1'b1;
    repeat (6) tick();
    check("t5_fifo_lost", 8'(busy), 8'h00);
    check("t5_no_issue", 8'(issued_n - base), 8'h00);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
